// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response port used by the fetch stage.
// The master drives req/addr; the slave answers with rdata/ready.
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, ready-handshaked imem port, one-entry skid buffer and IF/ID register.
// Optional feature macro: IF_PERF_CNT_EN adds fetch/flush performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    PC_write,
  input  logic                    ifid_write,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_target,
  if_fetch_stage_if.master        imem,
  output logic [31:0]             ifid_pc,
  output logic [31:0]             ifid_instr,
  output logic                    ifid_valid,
  output logic                    fetch_busy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] hold_pc, hold_instr;
  logic        hold_load;
  logic [31:0] ifid_pc_nxt, ifid_instr_nxt;
  logic        ifid_valid_nxt;
  logic        busy_nxt;
  logic        fetch_fire;

  assign imem.req  = (state == FETCH) || (state == DROP);
  assign imem.addr = addr_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_nxt      = state;
    pc_nxt         = pc;
    addr_nxt       = addr_q;
    hold_load      = 1'b0;
    ifid_pc_nxt    = ifid_pc;
    ifid_instr_nxt = ifid_instr;
    ifid_valid_nxt = ifid_valid;
    busy_nxt       = 1'b0;
    fetch_fire     = 1'b0;

    if (branch_taken) begin
      // Flush wins over every stall; an in-flight request without a response must still be drained.
      pc_nxt         = branch_target;
      ifid_pc_nxt    = 32'h0;
      ifid_instr_nxt = NOP_INSTR;
      ifid_valid_nxt = 1'b0;
      unique case (state)
        IDLE, HOLD: begin
          addr_nxt  = branch_target;
          state_nxt = FETCH;
        end
        FETCH: begin
          if (imem.ready) addr_nxt = branch_target;
          else            state_nxt = DROP;
        end
        DROP: begin
          if (imem.ready) begin
            addr_nxt  = branch_target;
            state_nxt = FETCH;
          end
        end
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          addr_nxt  = pc;
          state_nxt = FETCH;
        end
        FETCH: begin
          if (imem.ready) begin
            if (ifid_write) begin
              ifid_pc_nxt    = addr_q;
              ifid_instr_nxt = imem.rdata;
              ifid_valid_nxt = 1'b1;
              fetch_fire     = 1'b1;
              if (PC_write) pc_nxt = addr_q + 32'd4;
              addr_nxt = pc_nxt;
            end else begin
              hold_load = 1'b1;
              state_nxt = HOLD;
            end
          end else begin
            if (ifid_write) ifid_valid_nxt = 1'b0;
            busy_nxt = 1'b1;
          end
        end
        HOLD: begin
          if (ifid_write) begin
            ifid_pc_nxt    = hold_pc;
            ifid_instr_nxt = hold_instr;
            ifid_valid_nxt = 1'b1;
            fetch_fire     = 1'b1;
            if (PC_write) pc_nxt = hold_pc + 32'd4;
            addr_nxt  = pc_nxt;
            state_nxt = FETCH;
          end
        end
        DROP: begin
          if (imem.ready) begin
            addr_nxt  = pc;
            state_nxt = FETCH;
          end
        end
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments only; blocking is confined to always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      addr_q     <= RESET_PC;
      hold_pc    <= 32'h0;
      hold_instr <= 32'h0;
      ifid_pc    <= 32'h0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      fetch_busy <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      addr_q     <= addr_nxt;
      ifid_pc    <= ifid_pc_nxt;
      ifid_instr <= ifid_instr_nxt;
      ifid_valid <= ifid_valid_nxt;
      fetch_busy <= busy_nxt;
      if (hold_load) begin
        hold_pc    <= addr_q;
        hold_instr <= imem.rdata;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (fetch_fire)   perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (branch_taken) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
